ofdm_deintv2_param: RTL

Parametrised second-stage (intra-constellation) bit deinterleaver for the OFDM receive data field. It sits between the demapper and the first-stage deinterleaver. It handles BPSK/QPSK (pass-through), 16QAM and 64QAM, and carries soft bits of configurable width. It adds per-symbol framing, aligned sideband output and full-throughput ping-pong buffering, none of which the fixed 16QAM-only stage provides.

---
 rtl/ofdm_pkg.sv | 30 +++
 rtl/deintv2_grp_buf.sv | 99 +++++++++
 rtl/ofdm_deintv2_param.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// Shared OFDM receive definitions: modulation type, bit-group sizing and
// the per-group metadata carried through the second-stage deinterleaver.
package ofdm_pkg;

   typedef enum logic [1:0] {
      BPSK  = 2'b00,
      QPSK  = 2'b01,
      QAM16 = 2'b10,
      QAM64 = 2'b11
   } map_type_t;

   localparam int unsigned DEINTV2_COL_GRPS = 6;
   localparam int unsigned GRP_MAX          = 3;

   typedef struct packed {
      map_type_t  map;
      logic [1:0] nbits;
      logic       last;
   } grp_meta_t;

   // Bits per rotation group: 1 for BPSK/QPSK, 2 for 16QAM, 3 for 64QAM.
   function automatic logic [1:0] grp_size(input map_type_t m);
      case (m)
         QAM16:   return 2'd2;
         QAM64:   return 2'd3;
         default: return 2'd1;
      endcase
   endfunction

endpackage

// File: rtl/deintv2_grp_buf.sv
// Two-entry ping-pong group buffer with serial read-out; output registers are
// loaded from the buffer's next state so a written group appears the next cycle.
module deintv2_grp_buf
   import ofdm_pkg::*;
#(
   parameter int unsigned SOFT_W = 1,
   parameter int unsigned SYMB_W = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wr_en,
   input  logic [GRP_MAX-1:0][SOFT_W-1:0]    wr_data,
   input  grp_meta_t                         wr_meta,
   input  logic [SYMB_W-1:0]                 wr_symb,
   output logic                              wr_rdy_c,
   output logic [SOFT_W-1:0]                 dout,
   output logic                              dout_vld,
   output logic                              dout_last,
   input  logic                              dout_rdy,
   output logic [SYMB_W-1:0]                 dout_symb_cnt,
   output logic [1:0]                        dout_map_type
);

   typedef logic [GRP_MAX-1:0][SOFT_W-1:0] grp_data_t;

   grp_data_t         data_q [2];
   grp_data_t         data_n [2];
   grp_meta_t         meta_q [2];
   grp_meta_t         meta_n [2];
   logic [SYMB_W-1:0] symb_q [2];
   logic [SYMB_W-1:0] symb_n [2];
   logic              wr_ptr_q, wr_ptr_n;
   logic              rd_ptr_q, rd_ptr_n;
   logic [1:0]        cnt_q, cnt_n;
   logic [1:0]        bit_q, bit_n;
   logic              rd_fire;
   logic              rd_done;

   // A slot freed by the final read bit this cycle may be refilled at once.
   assign rd_fire  = dout_vld && dout_rdy;
   assign rd_done  = rd_fire && (bit_q == meta_q[rd_ptr_q].nbits - 2'd1);
   assign wr_rdy_c = !rst && ((cnt_q != 2'd2) || rd_done);

   always_comb begin
      data_n   = data_q;
      meta_n   = meta_q;
      symb_n   = symb_q;
      wr_ptr_n = wr_ptr_q;
      rd_ptr_n = rd_ptr_q;
      bit_n    = bit_q;
      if (wr_en) begin
         data_n[wr_ptr_q] = wr_data;
         meta_n[wr_ptr_q] = wr_meta;
         symb_n[wr_ptr_q] = wr_symb;
         wr_ptr_n         = !wr_ptr_q;
      end
      if (rd_done) begin
         rd_ptr_n = !rd_ptr_q;
         bit_n    = 2'd0;
      end else if (rd_fire) begin
         bit_n = bit_q + 2'd1;
      end
      cnt_n = cnt_q + 2'(wr_en) - 2'(rd_done);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            meta_q[i] <= '{map: BPSK, nbits: 2'd0, last: 1'b0};
            symb_q[i] <= '0;
         end
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         cnt_q         <= 2'd0;
         bit_q         <= 2'd0;
         dout          <= '0;
         dout_vld      <= 1'b0;
         dout_last     <= 1'b0;
         dout_symb_cnt <= '0;
         dout_map_type <= 2'b00;
      end else begin
         data_q        <= data_n;
         meta_q        <= meta_n;
         symb_q        <= symb_n;
         wr_ptr_q      <= wr_ptr_n;
         rd_ptr_q      <= rd_ptr_n;
         cnt_q         <= cnt_n;
         bit_q         <= bit_n;
         dout          <= data_n[rd_ptr_n][bit_n];
         dout_vld      <= (cnt_n != 2'd0);
         dout_last     <= meta_n[rd_ptr_n].last &&
                          (bit_n == meta_n[rd_ptr_n].nbits - 2'd1);
         dout_symb_cnt <= symb_n[rd_ptr_n];
         dout_map_type <= 2'(meta_n[rd_ptr_n].map);
      end
   end

endmodule

// File: rtl/ofdm_deintv2_param.sv
// Second-stage (intra-constellation) bit deinterleaver with symbol framing.
// Define DEINTV2_DUMP_EN to log accepted input/output bits (simulation only).
module ofdm_deintv2_param
   import ofdm_pkg::*;
#(
   parameter int unsigned SOFT_W = 1,
   parameter int unsigned SYMB_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SOFT_W-1:0] din,
   input  logic              din_vld,
   input  logic              din_last,
   output logic              din_rdy,
   input  logic [SYMB_W-1:0] din_symb_cnt,
   input  logic [1:0]        din_map_type,
   output logic [SOFT_W-1:0] dout,
   output logic              dout_vld,
   output logic              dout_last,
   input  logic              dout_rdy,
   output logic [SYMB_W-1:0] dout_symb_cnt,
   output logic [1:0]        dout_map_type,
   output logic              err_partial
);

   typedef logic [GRP_MAX-1:0][SOFT_W-1:0] grp_data_t;

   logic              sop_q;
   map_type_t         map_q;
   logic [SYMB_W-1:0] symb_q;
   logic [1:0]        k_q;
   logic [2:0]        g_q;
   logic [1:0]        r_q;
   grp_data_t         part_q;

   logic              din_fire;
   map_type_t         map_eff;
   logic [SYMB_W-1:0] symb_eff;
   logic [1:0]        s;
   grp_data_t         grp_cur;
   grp_data_t         grp_perm;
   logic              grp_full;
   logic [2:0]        t;
   logic [1:0]        idx;
   logic              wr_en;
   grp_data_t         wr_data;
   grp_meta_t         wr_meta;

   // Sideband comes straight from the port on the first bit, then from the captured copy.
   always_comb begin
      din_fire = din_vld && din_rdy;
      map_eff  = sop_q ? map_type_t'(din_map_type) : map_q;
      symb_eff = sop_q ? din_symb_cnt : symb_q;
      s        = grp_size(map_eff);
      grp_cur  = part_q;
      grp_cur[k_q] = din;
      grp_full = (k_q == s - 2'd1);
      grp_perm = '0;
      t        = 3'd0;
      idx      = 2'd0;
      for (int p = 0; p < GRP_MAX; p++) begin
         t = 3'(p) + 3'(s) - 3'(r_q);
         if (t >= 3'(s)) t = t - 3'(s);
         idx = t[1:0];
         if (3'(p) < 3'(s)) grp_perm[p] = grp_cur[idx];
      end
      wr_en         = din_fire && (grp_full || din_last);
      wr_data       = grp_full ? grp_perm : grp_cur;
      wr_meta.map   = map_eff;
      wr_meta.nbits = grp_full ? s : k_q + 2'd1;
      wr_meta.last  = din_last;
   end

   // Group/rotation counters; a short final group is flushed unrotated and flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         sop_q       <= 1'b1;
         map_q       <= BPSK;
         symb_q      <= '0;
         k_q         <= 2'd0;
         g_q         <= 3'd0;
         r_q         <= 2'd0;
         part_q      <= '0;
         err_partial <= 1'b0;
      end else if (din_fire) begin
         part_q <= grp_cur;
         map_q  <= map_eff;
         symb_q <= symb_eff;
         sop_q  <= din_last;
         if (din_last) begin
            k_q <= 2'd0;
            g_q <= 3'd0;
            r_q <= 2'd0;
            if (!grp_full) err_partial <= 1'b1;
         end else if (grp_full) begin
            k_q <= 2'd0;
            if (g_q == 3'(DEINTV2_COL_GRPS - 1)) begin
               g_q <= 3'd0;
               r_q <= (r_q == s - 2'd1) ? 2'd0 : r_q + 2'd1;
            end else begin
               g_q <= g_q + 3'd1;
            end
         end else begin
            k_q <= k_q + 2'd1;
         end
      end
   end

   deintv2_grp_buf #(
      .SOFT_W (SOFT_W),
      .SYMB_W (SYMB_W)
   ) u_grp_buf (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .wr_meta       (wr_meta),
      .wr_symb       (symb_eff),
      .wr_rdy_c      (din_rdy),
      .dout          (dout),
      .dout_vld      (dout_vld),
      .dout_last     (dout_last),
      .dout_rdy      (dout_rdy),
      .dout_symb_cnt (dout_symb_cnt),
      .dout_map_type (dout_map_type)
   );

`ifdef DEINTV2_DUMP_EN
   // Simulation-only trace of accepted input and output bits.
   always @(posedge clk) begin
      if (!rst && din_vld && din_rdy)   $display("deintv2_din %b", din);
      if (!rst && dout_vld && dout_rdy) $display("deintv2_dout %b", dout);
   end
`endif

endmodule
